// File: rtl/mem_stage.sv
// CP1 memory-access stage: issues aligned loads/stores on the data-memory port,
// waits for dmem_resp (with optional watchdog) and registers the stage word for WB.
package rv32i_pkg;
  typedef struct packed {
    logic       load_regfile;
    logic       dmem_read;
    logic       dmem_write;
    logic [2:0] funct3;
  } control_word_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_out;
    logic [31:0] rs2_out;
    logic [31:0] data_mdr;
    logic [4:0]  rd;
  } data_word_t;

  typedef struct packed {
    control_word_t ControlWord;
    data_word_t    DataWord;
  } rv32i_stage;
endpackage

module mem_stage
  import rv32i_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [$bits(rv32i_stage)-1:0] in_stage,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$bits(rv32i_stage)-1:0] out_stage,
  output logic                          out_misaligned,
  output logic                          out_bus_err,
  output logic [31:0]                   dmem_addr,
  output logic [3:0]                    dmem_rmask,
  output logic [3:0]                    dmem_wmask,
  output logic [31:0]                   dmem_wdata,
  input  logic [31:0]                   dmem_rdata,
  input  logic                          dmem_resp
);

  typedef enum logic {IDLE, MEM_WAIT} state_t;

  // funct3[1:0] encodes the access size: 00 byte, 01 half, 1x word
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   is_aligned = 1'b1;
      2'b01:   is_aligned = ~a[0];
      default: is_aligned = (a == 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   lane_mask = 4'b0001 << a;
      2'b01:   lane_mask = 4'b0011 << {a[1], 1'b0};
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [1:0] a,
                                             input logic [31:0] rs2);
    case (size)
      2'b00:   store_data = {24'b0, rs2[7:0]} << {a, 3'b000};
      2'b01:   store_data = {16'b0, rs2[15:0]} << {a[1], 4'b0000};
      default: store_data = rs2;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] rdata);
    logic [31:0] v_byte;
    logic [31:0] v_half;
    v_byte = rdata >> {a, 3'b000};
    v_half = rdata >> {a[1], 4'b0000};
    case (f3)
      3'b000:  load_ext = {{24{v_byte[7]}}, v_byte[7:0]};
      3'b100:  load_ext = {24'b0, v_byte[7:0]};
      3'b001:  load_ext = {{16{v_half[15]}}, v_half[15:0]};
      3'b101:  load_ext = {16'b0, v_half[15:0]};
      default: load_ext = rdata;
    endcase
  endfunction

  state_t      r_state;
  rv32i_stage  r_buf;
  rv32i_stage  r_out_stage;
  logic        r_out_valid;
  logic        r_out_mis;
  logic        r_out_berr;
  logic [31:0] r_dmem_addr;
  logic [31:0] r_dmem_wdata;
  logic [3:0]  r_rmask;
  logic [3:0]  r_wmask;
  logic [31:0] r_wait_cnt;

  rv32i_stage  w_in;
  rv32i_stage  w_pass;
  rv32i_stage  w_done;
  rv32i_stage  w_abort;
  logic        w_is_mem;
  logic        w_aligned;
  logic        w_accept;
  logic        w_timeout;
  logic [31:0] w_cnt_inc;
  logic [3:0]  w_mask;

  assign w_in      = in_stage;
  assign w_is_mem  = w_in.ControlWord.dmem_read | w_in.ControlWord.dmem_write;
  assign w_aligned = is_aligned(w_in.ControlWord.funct3[1:0], w_in.DataWord.alu_out[1:0]);
  assign w_mask    = lane_mask(w_in.ControlWord.funct3[1:0], w_in.DataWord.alu_out[1:0]);
  assign in_ready  = (r_state == IDLE) && (!r_out_valid || out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_cnt_inc = r_wait_cnt + 32'd1;
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (w_cnt_inc == TIMEOUT_CYCLES);

  // Misaligned accesses bypass memory and must not write the register file
  always_comb begin
    w_pass = w_in;
    w_pass.ControlWord.load_regfile = w_in.ControlWord.load_regfile & ~w_is_mem;
    w_done = r_buf;
    if (r_buf.ControlWord.dmem_read)
      w_done.DataWord.data_mdr = load_ext(r_buf.ControlWord.funct3,
                                          r_buf.DataWord.alu_out[1:0], dmem_rdata);
    w_abort = r_buf;
    w_abort.ControlWord.load_regfile = 1'b0;
    w_abort.DataWord.data_mdr        = 32'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_buf        <= '0;
      r_out_stage  <= '0;
      r_out_valid  <= 1'b0;
      r_out_mis    <= 1'b0;
      r_out_berr   <= 1'b0;
      r_dmem_addr  <= 32'b0;
      r_dmem_wdata <= 32'b0;
      r_rmask      <= 4'b0;
      r_wmask      <= 4'b0;
      r_wait_cnt   <= 32'b0;
    end else begin
      if (out_ready) r_out_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_is_mem && w_aligned) begin
              r_buf        <= w_in;
              r_state      <= MEM_WAIT;
              r_dmem_addr  <= {w_in.DataWord.alu_out[31:2], 2'b00};
              r_rmask      <= w_in.ControlWord.dmem_read ? w_mask : 4'b0;
              r_wmask      <= w_in.ControlWord.dmem_write ? w_mask : 4'b0;
              r_dmem_wdata <= w_in.ControlWord.dmem_write ?
                              store_data(w_in.ControlWord.funct3[1:0],
                                         w_in.DataWord.alu_out[1:0],
                                         w_in.DataWord.rs2_out) : 32'b0;
            end else begin
              r_out_stage <= w_pass;
              r_out_valid <= 1'b1;
              r_out_mis   <= w_is_mem;
              r_out_berr  <= 1'b0;
            end
          end
        end
        MEM_WAIT: begin
          if (dmem_resp || w_timeout) begin
            r_out_stage <= dmem_resp ? w_done : w_abort;
            r_out_valid <= 1'b1;
            r_out_mis   <= 1'b0;
            r_out_berr  <= ~dmem_resp;
            r_rmask     <= 4'b0;
            r_wmask     <= 4'b0;
            r_wait_cnt  <= 32'b0;
            r_state     <= IDLE;
          end else begin
            r_wait_cnt <= w_cnt_inc;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid      = r_out_valid;
  assign out_stage      = r_out_stage;
  assign out_misaligned = r_out_mis;
  assign out_bus_err    = r_out_berr;
  assign dmem_addr      = r_dmem_addr;
  assign dmem_rmask     = r_rmask;
  assign dmem_wmask     = r_wmask;
  assign dmem_wdata     = r_dmem_wdata;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, hand-written
// back-pressure / reset sequences, and randomized traffic against a reference model.
module tb_mem_stage;
  import rv32i_pkg::*;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  rv32i_stage  in_stage;
  logic        out_valid;
  logic        out_ready;
  logic [$bits(rv32i_stage)-1:0] out_stage;
  logic        out_misaligned;
  logic        out_bus_err;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_stage(in_stage),
    .out_valid(out_valid), .out_ready(out_ready), .out_stage(out_stage),
    .out_misaligned(out_misaligned), .out_bus_err(out_bus_err),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp)
  );

  typedef struct {
    rv32i_stage  stg;
    int          delay;
    logic [31:0] rdata;
    logic [3:0]  e_rmask;
    logic [3:0]  e_wmask;
    logic [31:0] e_wdata;
    logic [31:0] e_mdr;
    logic        e_mis;
    logic        e_berr;
  } vec_t;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic chk_stage(input string name, input rv32i_stage act, input rv32i_stage exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic rv32i_stage mk_stage(input logic dr, input logic dw, input logic [2:0] f3,
                                          input logic [31:0] alu, input logic [31:0] rs2);
    rv32i_stage s;
    s.ControlWord.load_regfile = ~dw;
    s.ControlWord.dmem_read    = dr;
    s.ControlWord.dmem_write   = dw;
    s.ControlWord.funct3       = f3;
    s.DataWord.pc              = $urandom;
    s.DataWord.alu_out         = alu;
    s.DataWord.rs2_out         = rs2;
    s.DataWord.data_mdr        = 32'h5A5A_5A5A;
    s.DataWord.rd              = 5'($urandom_range(1, 31));
    return s;
  endfunction

  function automatic vec_t tv(input logic dr, input logic dw, input logic [2:0] f3,
                              input logic [31:0] alu, input logic [31:0] rs2, input int delay,
                              input logic [31:0] rdata, input logic [3:0] er, input logic [3:0] ew,
                              input logic [31:0] ewd, input logic [31:0] emdr,
                              input logic emis, input logic eberr);
    vec_t v;
    v.stg = mk_stage(dr, dw, f3, alu, rs2);
    v.delay = delay; v.rdata = rdata;
    v.e_rmask = er; v.e_wmask = ew; v.e_wdata = ewd; v.e_mdr = emdr;
    v.e_mis = emis; v.e_berr = eberr;
    return v;
  endfunction

  // Reference model: byte-level arithmetic on access size and offset
  function automatic vec_t model(input rv32i_stage s, input int delay, input logic [31:0] rdata);
    vec_t v;
    longint unsigned size, off, m, val, lim;
    v.stg = s; v.delay = delay; v.rdata = rdata;
    v.e_rmask = 4'b0; v.e_wmask = 4'b0; v.e_wdata = 32'b0; v.e_mdr = 32'b0;
    v.e_mis = 1'b0; v.e_berr = 1'b0;
    if (!(s.ControlWord.dmem_read || s.ControlWord.dmem_write)) return v;
    size = (s.ControlWord.funct3[1:0] == 2'd0) ? 1 : (s.ControlWord.funct3[1:0] == 2'd1) ? 2 : 4;
    off  = longint'(s.DataWord.alu_out) % 4;
    if ((longint'(s.DataWord.alu_out) % size) != 0) begin
      v.e_mis = 1'b1;
      return v;
    end
    v.e_berr = (delay >= int'(TMO));
    m   = ((64'd1 << size) - 1) << off;
    lim = 64'd1 << (8 * size);
    if (s.ControlWord.dmem_read) v.e_rmask = 4'(m);
    else v.e_wmask = 4'(m);
    if (s.ControlWord.dmem_write)
      v.e_wdata = 32'((longint'(s.DataWord.rs2_out) % lim) * (64'd1 << (8 * off)));
    if (s.ControlWord.dmem_read && !v.e_berr) begin
      val = (longint'(rdata) / (64'd1 << (8 * off))) % lim;
      if (!s.ControlWord.funct3[2] && size < 4 && val >= lim / 2) val = val - lim;
      v.e_mdr = 32'(val);
    end
    return v;
  endfunction

  task automatic do_txn(input vec_t v, input int idx);
    rv32i_stage e;
    logic       is_mem;
    logic       done;
    e = v.stg;
    is_mem = v.stg.ControlWord.dmem_read | v.stg.ControlWord.dmem_write;
    if (is_mem && !v.e_mis && v.stg.ControlWord.dmem_read) e.DataWord.data_mdr = v.e_mdr;
    if (v.e_berr) e.DataWord.data_mdr = 32'b0;
    if (v.e_mis || v.e_berr) e.ControlWord.load_regfile = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1; in_stage = v.stg;
    #1;
    chk1("in_ready_accept", in_ready, 1'b1);
    step();
    in_valid = 1'b0; in_stage = '0;
    if (is_mem && !v.e_mis) begin
      done = 1'b0;
      for (int k = 0; k < 8 && !done; k++) begin
        chk32("dmem_addr", dmem_addr, v.stg.DataWord.alu_out & 32'hFFFF_FFFC);
        chk4("dmem_rmask", dmem_rmask, v.e_rmask);
        chk4("dmem_wmask", dmem_wmask, v.e_wmask);
        chk32("dmem_wdata", dmem_wdata, v.e_wdata);
        chk1("in_ready_wait", in_ready, 1'b0);
        chk1("out_valid_wait", out_valid, 1'b0);
        if (k == v.delay) begin
          dmem_resp = 1'b1; dmem_rdata = v.rdata;
        end else begin
          dmem_rdata = $urandom;
        end
        step();
        dmem_resp = 1'b0;
        if (k == v.delay || k == int'(TMO) - 1) done = 1'b1;
      end
    end
    chk1("out_valid", out_valid, 1'b1);
    chk_stage("out_stage", out_stage, e);
    chk1("out_misaligned", out_misaligned, v.e_mis);
    chk1("out_bus_err", out_bus_err, v.e_berr);
    chk4("rmask_idle", dmem_rmask, 4'b0);
    chk4("wmask_idle", dmem_wmask, 4'b0);
    $display("[TB] txn %0d rd=%0b wr=%0b f3=%0d alu=%08h delay=%0d mdr=%08h mis=%0b berr=%0b",
             idx, v.stg.ControlWord.dmem_read, v.stg.ControlWord.dmem_write,
             v.stg.ControlWord.funct3, v.stg.DataWord.alu_out, v.delay,
             e.DataWord.data_mdr, v.e_mis, v.e_berr);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        tab[17];
    vec_t        v;
    rv32i_stage  s_ld;
    rv32i_stage  s_alu;
    rv32i_stage  e_ld;
    logic [2:0]  lf[5];
    logic [2:0]  f3;
    int          kind;
    int          idx;

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_stage = '0;
    dmem_resp = 1'b0; dmem_rdata = 32'b0;
    #12;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk_stage("rst_out_stage", out_stage, '0);
    chk1("rst_misaligned", out_misaligned, 1'b0);
    chk1("rst_bus_err", out_bus_err, 1'b0);
    chk4("rst_rmask", dmem_rmask, 4'b0);
    chk4("rst_wmask", dmem_wmask, 4'b0);
    chk32("rst_addr", dmem_addr, 32'b0);
    chk32("rst_wdata", dmem_wdata, 32'b0);
    chk1("rst_in_ready", in_ready, 1'b1);
    step();
    rst = 1'b1;
    step();

    //            rd wr f3      alu           rs2           dly rdata         rmask    wmask    wdata         mdr           mis berr
    tab[0]  = tv(0, 0, 3'b000, 32'h0000_0042, 32'h0000_0000, 0, 32'h0,        4'b0000, 4'b0000, 32'h0,        32'h0,        0, 0);
    tab[1]  = tv(0, 0, 3'b111, 32'h0000_0100, 32'h1111_2222, 0, 32'h0,        4'b0000, 4'b0000, 32'h0,        32'h0,        0, 0);
    tab[2]  = tv(0, 0, 3'b010, 32'h0000_0007, 32'h3333_4444, 0, 32'h0,        4'b0000, 4'b0000, 32'h0,        32'h0,        0, 0);
    tab[3]  = tv(1, 0, 3'b000, 32'h0000_1003, 32'h0,         0, 32'h80AB_CDEF, 4'b1000, 4'b0000, 32'h0,        32'hFFFF_FF80, 0, 0);
    tab[4]  = tv(1, 0, 3'b100, 32'h0000_1003, 32'h0,         0, 32'h80AB_CDEF, 4'b1000, 4'b0000, 32'h0,        32'h0000_0080, 0, 0);
    tab[5]  = tv(0, 1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 3, 32'h0,        4'b0000, 4'b1100, 32'hABCD_0000, 32'h0,        0, 0);
    tab[6]  = tv(1, 0, 3'b010, 32'h0000_1001, 32'h0,         0, 32'h0,        4'b0000, 4'b0000, 32'h0,        32'h0,        1, 0);
    tab[7]  = tv(1, 0, 3'b001, 32'h0000_1002, 32'h0,         1, 32'h80AB_CDEF, 4'b1100, 4'b0000, 32'h0,        32'hFFFF_80AB, 0, 0);
    tab[8]  = tv(1, 0, 3'b101, 32'h0000_1000, 32'h0,         0, 32'h1234_F00D, 4'b0011, 4'b0000, 32'h0,        32'h0000_F00D, 0, 0);
    tab[9]  = tv(0, 1, 3'b000, 32'h0000_3001, 32'hDEAD_BEEF, 2, 32'h0,        4'b0000, 4'b0010, 32'h0000_EF00, 32'h0,        0, 0);
    tab[10] = tv(0, 1, 3'b010, 32'h0000_4000, 32'hCAFE_F00D, 0, 32'h0,        4'b0000, 4'b1111, 32'hCAFE_F00D, 32'h0,        0, 0);
    tab[11] = tv(0, 1, 3'b001, 32'h0000_2001, 32'h5555_6666, 0, 32'h0,        4'b0000, 4'b0000, 32'h0,        32'h0,        1, 0);
    tab[12] = tv(1, 0, 3'b010, 32'h0000_5000, 32'h0,         6, 32'hFFFF_FFFF, 4'b1111, 4'b0000, 32'h0,        32'h0,        0, 1);
    tab[13] = tv(1, 0, 3'b010, 32'h0000_6000, 32'h0,         2, 32'h0123_4567, 4'b1111, 4'b0000, 32'h0,        32'h0123_4567, 0, 0);
    tab[14] = tv(1, 0, 3'b000, 32'h0000_6001, 32'h0,         0, 32'h0123_4567, 4'b0010, 4'b0000, 32'h0,        32'h0000_0045, 0, 0);
    tab[15] = tv(1, 0, 3'b001, 32'h0000_6003, 32'h0,         0, 32'h0,        4'b0000, 4'b0000, 32'h0,        32'h0,        1, 0);
    tab[16] = tv(0, 1, 3'b000, 32'h0000_3003, 32'h0000_00A5, 3, 32'h0,        4'b0000, 4'b1000, 32'hA500_0000, 32'h0,        0, 0);

    idx = 0;
    for (int i = 0; i < 17; i++) begin
      do_txn(tab[i], idx);
      idx++;
    end

    // Completed load held by back-pressure, then drained while a new word is accepted
    s_ld  = mk_stage(1'b1, 1'b0, 3'b010, 32'h0000_7000, 32'h0);
    s_alu = mk_stage(1'b0, 1'b0, 3'b000, 32'h0000_0099, 32'h0);
    e_ld  = s_ld;
    e_ld.DataWord.data_mdr = 32'h1122_3344;
    step();
    out_ready = 1'b0; in_valid = 1'b1; in_stage = s_ld;
    #1;
    chk1("bp_accept_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    chk4("bp_rmask", dmem_rmask, 4'b1111);
    dmem_resp = 1'b1; dmem_rdata = 32'h1122_3344;
    step();
    dmem_resp = 1'b0;
    in_valid = 1'b1; in_stage = s_alu;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk1("bp_hold_valid", out_valid, 1'b1);
      chk_stage("bp_hold_stage", out_stage, e_ld);
      chk1("bp_hold_in_ready", in_ready, 1'b0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk1("bp_drain_in_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    chk1("bp_next_valid", out_valid, 1'b1);
    chk_stage("bp_next_stage", out_stage, s_alu);
    step();
    chk1("bp_drained", out_valid, 1'b0);

    lf[0] = 3'b000; lf[1] = 3'b001; lf[2] = 3'b010; lf[3] = 3'b100; lf[4] = 3'b101;
    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 2);
      if (kind == 1) f3 = lf[$urandom_range(0, 4)];
      else if (kind == 2) f3 = 3'($urandom_range(0, 2));
      else f3 = 3'($urandom_range(0, 7));
      v = model(mk_stage(kind == 1, kind == 2, f3, $urandom, $urandom),
                ($urandom_range(0, 7) == 0) ? 5 : $urandom_range(0, 3), $urandom);
      do_txn(v, idx);
      idx++;
    end

    // Asynchronous reset in the middle of a memory wait
    step();
    in_valid = 1'b1; in_stage = mk_stage(1'b1, 1'b0, 3'b010, 32'h0000_8000, 32'h0);
    step();
    in_valid = 1'b0;
    step();
    chk4("arst_pre_rmask", dmem_rmask, 4'b1111);
    #2 rst = 1'b0;
    #1;
    chk4("arst_rmask", dmem_rmask, 4'b0);
    chk4("arst_wmask", dmem_wmask, 4'b0);
    chk1("arst_out_valid", out_valid, 1'b0);
    chk32("arst_addr", dmem_addr, 32'b0);
    step();
    rst = 1'b1;
    #1;
    chk1("arst_idle_ready", in_ready, 1'b1);
    dmem_resp = 1'b1;
    step();
    dmem_resp = 1'b0;
    chk1("stray_resp_ignored", out_valid, 1'b0);
    out_ready = 1'b0; in_valid = 1'b1; in_stage = s_alu;
    step();
    in_valid = 1'b0;
    chk1("arst2_pre_valid", out_valid, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk1("arst2_out_valid", out_valid, 1'b0);
    chk_stage("arst2_out_stage", out_stage, '0);
    step();
    rst = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
